// File: rtl/mixer_dsm.sv
// mixer_dsm: weighted/panned stereo mixer of 1-bit audio sources feeding
// two first-order delta-sigma modulators that drive the 1-bit l/r pins.
// Levels are recomputed once per sample strobe and held in between.
module mixer_dsm #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int WEIGHT_W = 4,
  parameter int SUM_W    = 6,
  parameter int DIV      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   src,
  input  logic [1:0]            mode,
  input  logic                  cfgWe,
  input  logic [CH_W-1:0]       cfgCh,
  input  logic [WEIGHT_W+1:0]   cfgData,
  output logic [SUM_W-1:0]      levelL,
  output logic [SUM_W-1:0]      levelR,
  output logic                  l,
  output logic                  r
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CFG_W = WEIGHT_W + 2;
  // Default channel config: full weight, routed to both sides.
  localparam logic [CFG_W-1:0] CFG_DEFAULT = {2'b11, {WEIGHT_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_STEREO = 2'b00,
    MODE_MONO   = 2'b01,
    MODE_MUTE   = 2'b10,
    MODE_SWAP   = 2'b11
  } mode_e;

  // Registered state
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CFG_W-1:0]    cfg_q [CHANNELS];
  logic [CFG_W-1:0]    cfg_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    level_l_q, level_l_d;
  logic [SUM_W-1:0]    level_r_q, level_r_d;
  logic [SUM_W-1:0]    acc_l_q, acc_l_d;
  logic [SUM_W-1:0]    acc_r_q, acc_r_d;
  logic                l_q, l_d;
  logic                r_q, r_d;

  // Combinational helpers
  logic                strobe;
  logic [SUM_W-1:0]    sum_l, sum_r;
  logic [SUM_W:0]      dsm_l, dsm_r;

  // Sample-rate counter; strobe marks the last count of each period.
  always_comb begin
    strobe = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = strobe ? '0 : cnt_q + CNT_W'(1);
  end

  // Config register file write port; indices past CHANNELS match no entry.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cfg_d = cfg_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfgWe && (cfgCh == CH_W'(i))) cfg_d[i] = cfgData;
    end
  end

  // Weighted per-side sums and level update on the strobe.
  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2_q[i] && cfg_q[i][WEIGHT_W+1])
        sum_l = sum_l + SUM_W'(cfg_q[i][WEIGHT_W-1:0]);
      if (sync2_q[i] && cfg_q[i][WEIGHT_W])
        sum_r = sum_r + SUM_W'(cfg_q[i][WEIGHT_W-1:0]);
    end

    level_l_d = level_l_q;
    level_r_d = level_r_q;
    if (strobe) begin
      case (mode_e'(mode))
        MODE_STEREO: begin
          level_l_d = sum_l;
          level_r_d = sum_r;
        end
        MODE_MONO: begin
          // One extra bit keeps the carry of the two-side sum before halving.
          level_l_d = SUM_W'(({1'b0, sum_l} + {1'b0, sum_r}) >> 1);
          level_r_d = SUM_W'(({1'b0, sum_l} + {1'b0, sum_r}) >> 1);
        end
        MODE_MUTE: begin
          level_l_d = '0;
          level_r_d = '0;
        end
        MODE_SWAP: begin
          level_l_d = sum_r;
          level_r_d = sum_l;
        end
        default: begin
          level_l_d = level_l_q;
          level_r_d = level_r_q;
        end
      endcase
    end
  end

  // First-order delta-sigma: the accumulator carry is the output bit.
  always_comb begin
    dsm_l   = {1'b0, acc_l_q} + {1'b0, level_l_q};
    dsm_r   = {1'b0, acc_r_q} + {1'b0, level_r_q};
    acc_l_d = dsm_l[SUM_W-1:0];
    acc_r_d = dsm_r[SUM_W-1:0];
    l_d     = dsm_l[SUM_W];
    r_d     = dsm_r[SUM_W];
  end

  // State registers; reset wins over strobe and config writes on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      // NOTE: the config file is small and must come up at known defaults,
      // so it is reset like ordinary flops rather than left as bare storage.
      for (int i = 0; i < CHANNELS; i++) cfg_q[i] <= CFG_DEFAULT;
      cnt_q     <= '0;
      level_l_q <= '0;
      level_r_q <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      l_q       <= 1'b0;
      r_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q   <= src;
      sync2_q   <= sync1_q;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      level_l_q <= level_l_d;
      level_r_q <= level_r_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      l_q       <= l_d;
      r_q       <= r_d;
    end
  end

  assign levelL = level_l_q;
  assign levelR = level_r_q;
  assign l      = l_q;
  assign r      = r_q;

endmodule

// File: tb/tb_mixer_dsm.sv
// Directed testbench for mixer_dsm: a default 4-channel build plus a
// 3-channel build sharing the same stimulus (for out-of-range writes).
module tb_mixer_dsm;

  localparam int DIV = 64;

  logic       clock;
  logic       reset;
  logic [3:0] src;
  logic [1:0] mode;
  logic       cfgWe;
  logic [1:0] cfgCh;
  logic [5:0] cfgData;

  logic [5:0] levelL, levelR;
  logic       l, r;
  logic [5:0] levelL3, levelR3;
  logic       l3, r3;

  int total = 0;
  int bad   = 0;
  int tb_cnt;

  mixer_dsm #(.CHANNELS(4), .CH_W(2), .WEIGHT_W(4), .SUM_W(6), .DIV(DIV)) u_dut (
    .clock(clock), .reset(reset), .src(src), .mode(mode),
    .cfgWe(cfgWe), .cfgCh(cfgCh), .cfgData(cfgData),
    .levelL(levelL), .levelR(levelR), .l(l), .r(r)
  );

  mixer_dsm #(.CHANNELS(3), .CH_W(2), .WEIGHT_W(4), .SUM_W(6), .DIV(DIV)) u_dut3 (
    .clock(clock), .reset(reset), .src(src[2:0]), .mode(mode),
    .cfgWe(cfgWe), .cfgCh(cfgCh), .cfgData(cfgData),
    .levelL(levelL3), .levelR(levelR3), .l(l3), .r(r3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent model of the sample-strobe phase, used only for alignment.
  always @(posedge clock) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [5:0] data);
    @(negedge clock);
    cfgWe   = 1'b1;
    cfgCh   = ch;
    cfgData = data;
    @(negedge clock);
    cfgWe   = 1'b0;
  endtask

  // Count ones on each DSM output over n consecutive clocks.
  task automatic density(input int n, output int cl, output int cr,
                         output int c3l, output int c3r);
    cl = 0; cr = 0; c3l = 0; c3r = 0;
    repeat (n) begin
      @(negedge clock);
      if (l  === 1'b1) cl++;
      if (r  === 1'b1) cr++;
      if (l3 === 1'b1) c3l++;
      if (r3 === 1'b1) c3r++;
    end
  endtask

  // Step to the negedge where the model says the next posedge is a strobe.
  task automatic align_strobe(output int found);
    found = 0;
    for (int k = 0; k < 2 * DIV && found == 0; k++) begin
      if (tb_cnt == DIV - 1) found = 1;
      else @(negedge clock);
    end
  endtask

  task automatic check_levels(input string tag, input int el, input int er,
                              input int e3l, input int e3r);
    check({tag, "_levelL"},  32'(levelL),  32'(el));
    check({tag, "_levelR"},  32'(levelR),  32'(er));
    check({tag, "_levelL3"}, 32'(levelL3), 32'(e3l));
    check({tag, "_levelR3"}, 32'(levelR3), 32'(e3r));
  endtask

  initial begin
    int nz, cl, cr, c3l, c3r, found;

    reset = 1'b1; src = '0; mode = 2'b00;
    cfgWe = 1'b0; cfgCh = '0; cfgData = '0;
    wait_clk(3);
    check_levels("rst", 0, 0, 0, 0);
    check("rst_l", 32'(l), 0);
    check("rst_r", 32'(r), 0);
    reset = 1'b0;

    // Silent sources: everything stays at zero.
    nz = 0;
    repeat (1000) begin
      @(negedge clock);
      if (levelL !== '0 || levelR !== '0 || l !== 1'b0 || r !== 1'b0 ||
          levelL3 !== '0 || levelR3 !== '0 || l3 !== 1'b0 || r3 !== 1'b0)
        nz++;
    end
    check("idle_nonzero_cycles", 32'(nz), 0);

    // Single source at default weight.
    src = 4'b0001;
    wait_clk(2 * DIV + 4);
    check_levels("one_src", 15, 15, 15, 15);
    density(64, cl, cr, c3l, c3r);
    check("one_src_dens_l", 32'(cl), 15);
    check("one_src_dens_r", 32'(cr), 15);

    // All sources.
    src = 4'b1111;
    wait_clk(2 * DIV + 4);
    check_levels("all_src", 60, 60, 45, 45);
    density(64, cl, cr, c3l, c3r);
    check("all_src_dens_l",  32'(cl),  60);
    check("all_src_dens_r",  32'(cr),  60);
    check("all_src_dens_l3", 32'(c3l), 45);

    // Channel 2: weight 8, left only.
    cfg_write(2'd2, 6'b10_1000);
    wait_clk(2 * DIV + 4);
    check_levels("ch2_pan", 53, 45, 38, 30);
    density(64, cl, cr, c3l, c3r);
    check("ch2_pan_dens_l", 32'(cl), 53);
    check("ch2_pan_dens_r", 32'(cr), 45);

    mode = 2'b01;
    wait_clk(2 * DIV + 4);
    check_levels("mono", 49, 49, 34, 34);

    mode = 2'b11;
    wait_clk(2 * DIV + 4);
    check_levels("swap", 45, 53, 30, 38);

    mode = 2'b10;
    wait_clk(2 * DIV + 4);
    check_levels("mute", 0, 0, 0, 0);
    density(64, cl, cr, c3l, c3r);
    check("mute_dens_l", 32'(cl), 0);
    check("mute_dens_r", 32'(cr), 0);

    // Channel 3 weight 0: real in the 4-channel build, ignored in the 3-channel one.
    mode = 2'b00;
    cfg_write(2'd3, 6'b11_0000);
    wait_clk(2 * DIV + 4);
    check_levels("ch3_write", 38, 30, 38, 30);

    // Reset on a strobe edge with a concurrent config write.
    align_strobe(found);
    check("align1_found", 32'(found), 1);
    reset   = 1'b1;
    cfgWe   = 1'b1;
    cfgCh   = 2'd0;
    cfgData = 6'b00_0000;
    @(negedge clock);
    reset = 1'b0;
    cfgWe = 1'b0;
    check_levels("mid_rst", 0, 0, 0, 0);
    check("mid_rst_l",  32'(l),  0);
    check("mid_rst_r",  32'(r),  0);
    check("mid_rst_l3", 32'(l3), 0);

    // First strobe after reset: levels still zero just before, defaults after.
    align_strobe(found);
    check("align2_found", 32'(found), 1);
    check_levels("pre_strobe", 0, 0, 0, 0);
    @(negedge clock);
    check_levels("post_rst_default", 60, 60, 45, 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mixer_dsm.md
Name: mixer_dsm

Overview:
- Parametrised successor to the fixed speaker/ear/mic mixer.
- Sums CHANNELS 1-bit audio sources (speaker, ear, mic, future beeper/tape/expansion) into stereo levels using per-channel weight and pan registers written at run time.
- Levels are resampled on a programmable strobe and converted by two first-order delta-sigma modulators to the 1-bit l/r audio pins.
- Sits at top level on the 70 MHz system clock, between the ULA audio bits and the audio pins.

Parameters:
- CHANNELS, 4, number of 1-bit sources (1..16).
- CH_W, 2, width of channel index; 2^CH_W >= CHANNELS.
- WEIGHT_W, 4, weight width per channel.
- SUM_W, 6, level width; 2^SUM_W >= CHANNELS*(2^WEIGHT_W-1).
- DIV, 64, clocks per sample strobe (>=2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src  in  CHANNELS  raw 1-bit sources; asynchronous, bit i = channel i.
- mode  in  2  00 stereo, 01 mono, 10 mute, 11 swap L/R.
- cfgWe  in  1  config write strobe, one clock.
- cfgCh  in  CH_W  channel index for write.
- cfgData  in  WEIGHT_W+2  [WEIGHT_W+1] panL, [WEIGHT_W] panR, [WEIGHT_W-1:0] weight.
- levelL  out  SUM_W  current left level (debug/test).
- levelR  out  SUM_W  current right level.
- l  out  1  left delta-sigma bit.
- r  out  1  right delta-sigma bit.

Behaviour:
- Reset (synchronous, active-high): all weights = 2^WEIGHT_W-1 with panL=panR=1; strobe counter, sync flops, levelL/R, both accumulators, l and r = 0.
- Input sync: src passes through 2-FF synchroniser per bit; 2-clock latency before use.
- Config:
  - cfgWe=1 with cfgCh<CHANNELS writes cfgData to that channel's register at the clock edge.
  - cfgCh>=CHANNELS: write ignored.
  - Writes are never blocked.
- Strobe counter: counts 0..DIV-1 and wraps; strobe = (count==DIV-1).
- On strobe:
  - sumL = sum of weight_i over channels with synced src_i=1 and panL_i=1.
  - sumR = same using panR_i.
  - Arithmetic is unsigned SUM_W bits; by parameter rule no overflow is possible.
  - Register update by mode:
    - stereo: levelL<=sumL, levelR<=sumR.
    - mono: both <= (sumL+sumR)>>1, computed at SUM_W+1 bits.
    - mute: both <= 0.
    - swap: levelL<=sumR, levelR<=sumL.
  - Weights and mode are sampled at the strobe edge; a write on the strobe clock is not seen until the next strobe.
- Between strobes, levelL/R hold.
- DSM, every clock, per side: {carry,acc} <= acc + level, with SUM_W-bit acc; output bit (l or r) <= carry (registered).
  - Output density = level/2^SUM_W exactly over any 2^SUM_W clocks with constant level.
  - Level 0 gives constant 0.
  - Accumulator is not cleared on level change; it is cleared only by reset.
- Reset mid-operation overrides everything on that edge, including a concurrent strobe or cfgWe.
- No handshakes out; block is free-running.

Test Plan:
- Reset, src=0, default config, mode=00, run 1000 clocks -> levelL=levelR=0, l=r=0 throughout.
- src=4'b0001, defaults, mode=00 -> after first strobe levelL=levelR=15; l high exactly 15 of every 64 consecutive clocks.
- src=4'b1111, defaults -> levels=60, l/r density 60/64. Then write ch2 cfgData={1,0,4'd8} -> after next strobe levelL=53, levelR=45.
- Same config as previous, mode=01 -> levels=(53+45)>>1=49. mode=11 -> levelL=45, levelR=53. mode=10 -> both 0, l/r settle to 0.
- cfgWe with cfgCh=3 and data {1,1,4'd0}, then cfgCh out of range (CHANNELS=3 build, cfgCh=3) -> out-of-range write leaves all registers unchanged.
- Assert reset for 1 clock mid-stream coinciding with strobe and cfgWe -> next clock all outputs 0, weights back to default 15/both.
